// File: rtl/arc4_pkg.sv
// arc4_pkg: shared types for the ARC4 phase sequencer.
// Optional watchdog macro: ARC4_SCHED_WATCHDOG_EN.
package arc4_pkg;

  localparam int S_DEPTH = 256;
  localparam int S_AW    = $clog2(S_DEPTH);

  typedef enum logic [2:0] {
    IDLE,
    INIT_START,
    INIT_RUN,
    KSA_START,
    KSA_RUN,
    PRGA_START,
    PRGA_RUN,
    ERR
  } sched_state_t;

  typedef struct packed {
    logic [S_AW-1:0] addr;
    logic [7:0]      wrdata;
    logic            wren;
  } mem_req_t;

  // One-hot {prga,ksa,init} owner of a state
  function automatic logic [2:0] phase_of(
    input sched_state_t s
  );
    unique case (s)
      INIT_START, INIT_RUN: return 3'b001;
      KSA_START, KSA_RUN:   return 3'b010;
      PRGA_START, PRGA_RUN: return 3'b100;
      default:              return 3'b000;
    endcase
  endfunction

endpackage

// File: rtl/arc4_phase_hs.sv
// arc4_phase_hs: start/run handshake shared by all sequencer phases.
// Optional watchdog macro (in top): ARC4_SCHED_WATCHDOG_EN.
module arc4_phase_hs (
  input  logic CLOCK_50,
  input  logic rst_n,
  input  logic i_start,
  input  logic i_run,
  input  logic i_rdy,
  output logic o_en,
  output logic o_done
);

  logic r_busy_seen;

  // Completion needs the engine to have dropped rdy at least once
  always_ff @(posedge CLOCK_50) begin
    if (!rst_n)
      r_busy_seen <= 1'b0;
    else if (!i_run)
      r_busy_seen <= 1'b0;
    else if (!i_rdy)
      r_busy_seen <= 1'b1;
  end

  assign o_en   = i_start & i_rdy;
  assign o_done = i_run & i_rdy & r_busy_seen;

endmodule

// File: rtl/arc4_sched.sv
// arc4_sched: sequences init, ksa and prga engines and owns the S port.
// Optional phase watchdog: define ARC4_SCHED_WATCHDOG_EN.
module arc4_sched
  import arc4_pkg::*;
#(
  parameter int KEY_W     = 24,
  parameter int WD_CYCLES = 65535
) (
  input  logic             CLOCK_50,
  input  logic             rst_n,
  input  logic             en,
  output logic             rdy,
  input  logic [KEY_W-1:0] key,
  output logic [KEY_W-1:0] key_q,
  output logic             init_en,
  output logic             ksa_en,
  output logic             prga_en,
  input  logic             init_rdy,
  input  logic             ksa_rdy,
  input  logic             prga_rdy,
  input  logic [7:0]       init_addr,
  input  logic [7:0]       ksa_addr,
  input  logic [7:0]       prga_addr,
  input  logic [7:0]       init_wrdata,
  input  logic [7:0]       ksa_wrdata,
  input  logic [7:0]       prga_wrdata,
  input  logic             init_wren,
  input  logic             ksa_wren,
  input  logic             prga_wren,
  output logic [7:0]       s_addr,
  output logic [7:0]       s_wrdata,
  output logic             s_wren,
  output logic [2:0]       phase,
  output logic             err
);

  sched_state_t     r_state;
  logic [KEY_W-1:0] r_key;
  logic             w_start;
  logic             w_run;
  logic             w_rdy;
  logic             w_en;
  logic             w_done;
  logic             w_trip;
  mem_req_t         w_req;

  always_comb begin
    w_rdy = 1'b0;
    w_req = '0;
    unique case (r_state)
      INIT_START, INIT_RUN: begin
        w_rdy = init_rdy;
        w_req = '{init_addr, init_wrdata, init_wren};
      end
      KSA_START, KSA_RUN: begin
        w_rdy = ksa_rdy;
        w_req = '{ksa_addr, ksa_wrdata, ksa_wren};
      end
      PRGA_START, PRGA_RUN: begin
        w_rdy = prga_rdy;
        w_req = '{prga_addr, prga_wrdata, prga_wren};
      end
      default: ;
    endcase
  end

  assign w_start = (r_state == INIT_START)
                 | (r_state == KSA_START)
                 | (r_state == PRGA_START);
  assign w_run   = (r_state == INIT_RUN)
                 | (r_state == KSA_RUN)
                 | (r_state == PRGA_RUN);

  arc4_phase_hs u_hs (
    .CLOCK_50 (CLOCK_50),
    .rst_n    (rst_n),
    .i_start  (w_start),
    .i_run    (w_run),
    .i_rdy    (w_rdy),
    .o_en     (w_en),
    .o_done   (w_done)
  );

`ifdef ARC4_SCHED_WATCHDOG_EN
  localparam logic [15:0] WD_LIM = 16'(WD_CYCLES - 1);

  logic [15:0] r_wd;

  // Cleared outside START/RUN and on completion, so each START begins at 0
  always_ff @(posedge CLOCK_50) begin
    if (!rst_n)
      r_wd <= '0;
    else if ((w_start | w_run) & ~w_done)
      r_wd <= r_wd + 16'd1;
    else
      r_wd <= '0;
  end

  assign w_trip = (w_start | w_run)
                & ~(w_en | w_done)
                & (r_wd == WD_LIM);
  assign err    = (r_state == ERR);
`else
  logic w_unused_wd;

  assign w_unused_wd = (WD_CYCLES != 0);
  assign w_trip      = 1'b0;
  assign err         = 1'b0;
`endif

  always_ff @(posedge CLOCK_50) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_key   <= '0;
    end else begin
      unique case (r_state)
        IDLE:
          if (en) begin
            r_state <= INIT_START;
            r_key   <= key;
          end
        INIT_START: if (w_en)   r_state <= INIT_RUN;
        INIT_RUN:   if (w_done) r_state <= KSA_START;
        KSA_START:  if (w_en)   r_state <= KSA_RUN;
        KSA_RUN:    if (w_done) r_state <= PRGA_START;
        PRGA_START: if (w_en)   r_state <= PRGA_RUN;
        PRGA_RUN:   if (w_done) r_state <= IDLE;
        default:    r_state <= r_state;
      endcase
      if (w_trip)
        r_state <= ERR;
    end
  end

  assign rdy      = (r_state == IDLE);
  assign key_q    = r_key;
  assign phase    = phase_of(r_state);
  assign init_en  = w_en & (r_state == INIT_START);
  assign ksa_en   = w_en & (r_state == KSA_START);
  assign prga_en  = w_en & (r_state == PRGA_START);
  assign s_addr   = w_req.addr;
  assign s_wrdata = w_req.wrdata;
  assign s_wren   = w_req.wren;

endmodule

// File: tb/tb_arc4_sched.sv
// tb_arc4_sched: random engine timings checked against a phase-timeline model.
// Watchdog scenario compiled in with ARC4_SCHED_WATCHDOG_EN.
module tb_arc4_sched;

  localparam int KW = 24;
`ifdef ARC4_SCHED_WATCHDOG_EN
  localparam int WD = 16;
`else
  localparam int WD = 1 << 30;
`endif
  localparam int LB    = (WD < 300) ? 8 : 256;
  localparam int LP    = (WD < 300) ? 4 : 32;
  localparam int BMAX  = (WD < 300) ? 10 : 40;
  localparam int MID   = (LB > 200) ? 100 : LB / 2;

  logic          CLOCK_50 = 1'b0;
  logic          rst_n;
  logic          en;
  logic [KW-1:0] key;
  logic          rdy;
  logic [KW-1:0] key_q;
  logic          init_en, ksa_en, prga_en;
  logic          e_rdy  [3];
  logic [7:0]    e_addr [3];
  logic [7:0]    e_wd   [3];
  logic          e_wren [3];
  logic [7:0]    s_addr, s_wrdata;
  logic          s_wren;
  logic [2:0]    phase;
  logic          err;

  always #10 CLOCK_50 = ~CLOCK_50;

  arc4_sched #(
    .KEY_W     (KW),
    .WD_CYCLES (16)
  ) dut (
    .CLOCK_50    (CLOCK_50),
    .rst_n       (rst_n),
    .en          (en),
    .rdy         (rdy),
    .key         (key),
    .key_q       (key_q),
    .init_en     (init_en),
    .ksa_en      (ksa_en),
    .prga_en     (prga_en),
    .init_rdy    (e_rdy[0]),
    .ksa_rdy     (e_rdy[1]),
    .prga_rdy    (e_rdy[2]),
    .init_addr   (e_addr[0]),
    .ksa_addr    (e_addr[1]),
    .prga_addr   (e_addr[2]),
    .init_wrdata (e_wd[0]),
    .ksa_wrdata  (e_wd[1]),
    .prga_wrdata (e_wd[2]),
    .init_wren   (e_wren[0]),
    .ksa_wren    (e_wren[1]),
    .prga_wren   (e_wren[2]),
    .s_addr      (s_addr),
    .s_wrdata    (s_wrdata),
    .s_wren      (s_wren),
    .phase       (phase),
    .err         (err)
  );

  int n_chk = 0;
  int n_fail = 0;
  int cyc = 0;

  task automatic check(
    input string       tag,
    input logic [63:0] got,
    input logic [63:0] exp
  );
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s cyc=%0d got=%h expected=%h",
               tag, cyc, got, exp);
    end
  endtask

  // Model: a run accepted in cycle a owns phase p for m_t[p] cycles
  bit            m_busy = 1'b0;
  int            m_a = 0;
  int            m_t [3];
  logic [KW-1:0] m_key = '0;
  int            p_d [3];
  int            p_b [3];
  int            e_hi [3];
  int            e_lo [3];
  int            n_en [3];
  bit            force_init = 1'b0;

  task automatic set_params(
    input int d0, input int b0,
    input int d1, input int b1,
    input int d2, input int b2
  );
    p_d[0] = d0; p_b[0] = b0;
    p_d[1] = d1; p_b[1] = b1;
    p_d[2] = d2; p_b[2] = b2;
  endtask

  task automatic model_exp(
    output int own, output bit er, output bit first
  );
    int r;
    own = -1; er = 1'b0; first = 1'b0;
    if (m_busy) begin
      r = cyc - m_a - 1;
      for (int p = 0; p < 3; p++) begin
        if (own < 0 && !er) begin
          if (m_t[p] > WD && r >= WD) er = 1'b1;
          else if (r < m_t[p]) begin
            own = p;
            first = (r == 0);
          end else r -= m_t[p];
        end
      end
    end
  endtask

  task automatic step();
    int         own;
    bit         er, first, idle, rst_seen;
    bit  [2:0]  en_seen;
    logic [16:0] mexp;
    @(negedge CLOCK_50);
    model_exp(own, er, first);
    idle = (own < 0) && !er;
    check("ctl",
          {rdy, phase, prga_en, ksa_en, init_en, err},
          {idle, own == 2, own == 1, own == 0,
           first && own == 2, first && own == 1,
           first && own == 0, er});
    mexp = '0;
    if (own >= 0)
      mexp = {e_wren[own], e_addr[own], e_wd[own]};
    check("smux", {s_wren, s_addr, s_wrdata}, mexp);
    check("key_q", key_q, m_key);
    en_seen = {prga_en, ksa_en, init_en};
    for (int p = 0; p < 3; p++) n_en[p] += int'(en_seen[p]);
    rst_seen = !rst_n;
    if (rst_seen) begin
      m_busy = 1'b0;
      m_key = '0;
    end else if (idle) begin
      m_busy = 1'b0;
      if (en) begin
        m_busy = 1'b1;
        m_a = cyc;
        m_key = key;
        for (int p = 0; p < 3; p++) m_t[p] = 2 + p_d[p] + p_b[p];
      end
    end
    @(posedge CLOCK_50);
    #1;
    cyc++;
    for (int p = 0; p < 3; p++) begin
      if (rst_seen) begin
        e_hi[p] = 0; e_lo[p] = 0; e_rdy[p] = 1'b1;
      end else begin
        if (en_seen[p]) begin
          e_hi[p] = p_d[p];
          e_lo[p] = p_b[p];
        end
        if (e_hi[p] > 0) begin
          e_rdy[p] = 1'b1; e_hi[p]--;
        end else if (e_lo[p] > 0) begin
          e_rdy[p] = 1'b0; e_lo[p]--;
        end else e_rdy[p] = 1'b1;
      end
      e_addr[p] = 8'($urandom);
      e_wd[p]   = 8'($urandom);
      e_wren[p] = 1'($urandom);
    end
    if (force_init) begin
      e_wren[0] = 1'b1;
      e_addr[0] = 8'hAA;
    end
  endtask

  task automatic run_idle(input int budget);
    int n;
    n = 0;
    while (m_busy && n < budget) begin
      step();
      n++;
    end
    check("run_done", {63'b0, m_busy}, 64'd0);
  endtask

  task automatic start_run(input logic [KW-1:0] k);
    for (int p = 0; p < 3; p++) n_en[p] = 0;
    key = k;
    en = 1'b1;
    step();
    en = 1'b0;
  endtask

  task automatic check_pulses();
    check("init_en_cnt", 64'(n_en[0]), 64'd1);
    check("ksa_en_cnt", 64'(n_en[1]), 64'd1);
    check("prga_en_cnt", 64'(n_en[2]), 64'd1);
  endtask

  initial begin
    int tot, rnd_n;
    rst_n = 1'b0; en = 1'b0; key = '0;
    for (int p = 0; p < 3; p++) begin
      e_rdy[p] = 1'b1; e_addr[p] = '0; e_wd[p] = '0;
      e_wren[p] = 1'b0; e_hi[p] = 0; e_lo[p] = 0;
      n_en[p] = 0;
    end
    set_params(0, 1, 0, 1, 0, 1);
    @(posedge CLOCK_50);
    #1;
    en = 1'b1;
    step();
    step();
    en = 1'b0;
    rst_n = 1'b1;
    step();

    // Nominal run, engines busy 256/256/32
    set_params(0, LB, 0, LB, 0, LP);
    start_run(24'h00033C);
    run_idle(2000);
    check_pulses();
    check("key_q_hold", key_q, 24'h00033C);

    // Engine keeps rdy high for 3 cycles after en
    set_params(3, 10, 3, 10, 3, 6);
    start_run(24'hA5A5A5);
    run_idle(200);
    check_pulses();

    // Init engine writes 0xAA throughout ksa/prga
    set_params(0, 12, 0, 12, 0, 5);
    start_run(24'h123456);
    while (m_busy && cyc <= m_a + m_t[0]) step();
    force_init = 1'b1;
    run_idle(200);
    force_init = 1'b0;

    // Reset mid-ksa, then a fresh run from init
    set_params(0, LB, 0, LB, 0, LP);
    start_run(24'hBEEF01);
    while (cyc < m_a + m_t[0] + 1 + MID) step();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    check("mid_rst", {rdy, phase, s_wren}, 5'b10000);
    step();
    set_params(1, 5, 0, 7, 2, 3);
    start_run(24'h0F0F0F);
    run_idle(200);
    check_pulses();

    // en held high: back-to-back runs, key only latched in IDLE
    en = 1'b1;
    key = KW'($urandom);
    tot = 2 * (m_t[0] + m_t[1] + m_t[2] + 1) + 3;
    repeat (tot) begin
      step();
      key = KW'($urandom);
    end
    en = 1'b0;
    run_idle(200);

    // Random timings with stray en pulses while busy
    for (int r = 0; r < 8; r++) begin
      set_params($urandom_range(0, 4), $urandom_range(1, BMAX),
                 $urandom_range(0, 4), $urandom_range(1, BMAX),
                 $urandom_range(0, 4), $urandom_range(1, BMAX));
      repeat ($urandom_range(0, 3)) step();
      start_run(KW'($urandom));
      rnd_n = m_t[0] + m_t[1] + m_t[2] - 1;
      repeat (rnd_n) begin
        en = 1'($urandom_range(0, 3) == 0);
        key = KW'($urandom);
        step();
      end
      en = 1'b0;
      run_idle(20);
      check_pulses();
    end

`ifdef ARC4_SCHED_WATCHDOG_EN
    // Init engine never returns rdy
    set_params(0, 1000, 0, 4, 0, 4);
    start_run(24'h00BAD0);
    repeat (WD + 10) begin
      en = 1'($urandom);
      step();
    end
    en = 1'b0;
    check("wd_err", {err, rdy}, 2'b10);
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    check("wd_clear", {err, rdy}, 2'b01);
    step();
`endif

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
